// File: rtl/primitive_fifo.sv
// Primitive-assembly FIFO: groups VERTS vertices into a primitive and holds DEPTH primitives, show-ahead output.
// Latency: completing vertex at cycle N -> valid_out at N+1. Backpressure: only the completing vertex stalls when full.
// Optional build macro PRIMITIVE_FIFO_DEGEN_CULL_EN drops primitives with coincident x/y and adds cull_count_out.
module primitive_fifo #(
    parameter int WIDTH      = 32,
    parameter int COMPONENTS = 4,
    parameter int VERTS      = 3,
    parameter int DEPTH      = 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                flush_in,
    input  logic                                valid_in,
    input  logic [COMPONENTS*WIDTH-1:0]         vertex_in,
    output logic                                ready_out,
    output logic                                valid_out,
    input  logic                                ready_in,
    output logic [VERTS*COMPONENTS*WIDTH-1:0]   primitive_out,
    output logic [ID_WIDTH-1:0]                 id_out,
    output logic [$clog2(DEPTH+1)-1:0]          count_out,
    output logic                                overflow_out
`ifdef PRIMITIVE_FIFO_DEGEN_CULL_EN
    ,
    output logic [15:0]                         cull_count_out
`endif
);

    localparam int VW   = COMPONENTS * WIDTH;
    localparam int PW   = VERTS * VW;
    localparam int AW   = $clog2(VERTS);
    localparam int PTRW = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);

    logic [AW-1:0]       r_asm_idx;
    logic [VW-1:0]       r_asm [VERTS-1];
    logic [PTRW-1:0]     r_wr_ptr;
    logic [PTRW-1:0]     r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [ID_WIDTH-1:0] r_id;
    logic                r_overflow;
    logic [PW-1:0]       r_mem    [DEPTH];
    logic [ID_WIDTH-1:0] r_mem_id [DEPTH];

    logic                w_last_slot;
    logic                w_accept;
    logic                w_complete;
    logic                w_degen;
    logic                w_store;
    logic                w_pop;
    logic [PW-1:0]       w_prim;

    assign w_last_slot = (r_asm_idx == AW'(VERTS - 1));
    assign ready_out   = !((r_count == CW'(DEPTH)) && w_last_slot);
    assign w_accept    = valid_in && ready_out && !flush_in;
    assign w_complete  = w_accept && w_last_slot;
    assign w_store     = w_complete && !w_degen;
    assign w_pop       = valid_out && ready_in && !flush_in;

    assign valid_out     = (r_count != '0);
    assign primitive_out = r_mem[r_rd_ptr];
    assign id_out        = r_mem_id[r_rd_ptr];
    assign count_out     = r_count;
    assign overflow_out  = r_overflow;

    always_comb begin
        w_prim = '0;
        for (int j = 0; j < VERTS - 1; j++) begin
            w_prim[j*VW +: VW] = r_asm[j];
        end
        w_prim[(VERTS-1)*VW +: VW] = vertex_in;
    end

`ifdef PRIMITIVE_FIFO_DEGEN_CULL_EN
    logic [15:0] r_cull_count;

    // x and y are adjacent, so one 2*WIDTH slice compares both at once
    always_comb begin
        w_degen = 1'b0;
        for (int i = 0; i < VERTS - 1; i++) begin
            for (int k = i + 1; k < VERTS; k++) begin
                if (w_prim[i*VW +: 2*WIDTH] == w_prim[k*VW +: 2*WIDTH]) begin
                    w_degen = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cull_count <= '0;
        end else if (flush_in) begin
            r_cull_count <= '0;
        end else if (w_complete && w_degen && (r_cull_count != 16'hFFFF)) begin
            r_cull_count <= r_cull_count + 16'd1;
        end
    end

    assign cull_count_out = r_cull_count;
`else
    assign w_degen = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_asm_idx  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_id       <= '0;
            r_overflow <= 1'b0;
        end else if (flush_in) begin
            r_asm_idx  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_id       <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (valid_in && !ready_out) begin
                r_overflow <= 1'b1;
            end
            if (w_accept) begin
                r_asm_idx <= w_last_slot ? '0 : r_asm_idx + AW'(1);
            end
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + PTRW'(1);
                r_id     <= r_id + ID_WIDTH'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTRW'(1);
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Data storage carries no reset; validity is tracked by r_count and r_asm_idx
    always_ff @(posedge clk_in) begin
        for (int j = 0; j < VERTS - 1; j++) begin
            if (w_accept && (r_asm_idx == AW'(j))) begin
                r_asm[j] <= vertex_in;
            end
        end
        if (w_store) begin
            r_mem[r_wr_ptr]    <= w_prim;
            r_mem_id[r_wr_ptr] <= r_id;
        end
    end

endmodule

// File: tb/tb_primitive_fifo.sv
// Bench for primitive_fifo (DEPTH=4): scoreboard of expected primitives checked by a monitor on each pop.
module tb_primitive_fifo;
    localparam int W   = 32;
    localparam int C   = 4;
    localparam int V   = 3;
    localparam int D   = 4;
    localparam int IDW = 8;
    localparam int VW  = W * C;
    localparam int PRW = V * VW;
    localparam int CW  = $clog2(D + 1);

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b0;
    logic           flush_in = 1'b0;
    logic           valid_in = 1'b0;
    logic           ready_in = 1'b0;
    logic [VW-1:0]  vertex_in = '0;
    logic           ready_out;
    logic           valid_out;
    logic [PRW-1:0] primitive_out;
    logic [IDW-1:0] id_out;
    logic [CW-1:0]  count_out;
    logic           overflow_out;
`ifdef PRIMITIVE_FIFO_DEGEN_CULL_EN
    logic [15:0]    cull_count_out;
`endif

    primitive_fifo #(.WIDTH(W), .COMPONENTS(C), .VERTS(V), .DEPTH(D), .ID_WIDTH(IDW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .valid_in(valid_in), .vertex_in(vertex_in), .ready_out(ready_out),
        .valid_out(valid_out), .ready_in(ready_in), .primitive_out(primitive_out),
        .id_out(id_out), .count_out(count_out), .overflow_out(overflow_out)
`ifdef PRIMITIVE_FIFO_DEGEN_CULL_EN
        , .cull_count_out(cull_count_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [PRW-1:0] prim;
        logic [IDW-1:0] id;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int rx    = 0;

    int             m_cnt  = 0;
    int             m_asm  = 0;
    logic [IDW-1:0] m_id   = '0;
    logic           m_ovf  = 1'b0;
    logic [15:0]    m_cull = '0;
    logic [VW-1:0]  m_slot [V-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] mkv(input int x, input int y, input int z);
        return {32'(z + 7), 32'(z), 32'(y), 32'(x)};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_asm = 0; m_id = '0; m_ovf = 1'b0; m_cull = '0;
        sb.delete();
    endtask

    // One clock: drive inputs, advance the reference model, then check registered outputs
    task automatic cycle(input logic v, input logic [VW-1:0] vx, input logic rdy,
                         input logic fl, output logic acc);
        logic           m_ready;
        logic           deg;
        int             push;
        int             pop;
        logic [PRW-1:0] p;
        exp_t           e;
        valid_in = v; vertex_in = vx; ready_in = rdy; flush_in = fl;
        m_ready = !(m_cnt == D && m_asm == V - 1);
        chk("ready_out", 32'(ready_out), 32'(m_ready));
        acc = 1'b0;
        if (fl) begin
            model_reset();
        end else begin
            push = 0;
            pop  = (m_cnt != 0 && rdy) ? 1 : 0;
            if (v && !m_ready) m_ovf = 1'b1;
            if (v && m_ready) begin
                acc = 1'b1;
                if (m_asm == V - 1) begin
                    for (int j = 0; j < V - 1; j++) p[j*VW +: VW] = m_slot[j];
                    p[(V-1)*VW +: VW] = vx;
                    deg = 1'b0;
`ifdef PRIMITIVE_FIFO_DEGEN_CULL_EN
                    for (int i = 0; i < V - 1; i++)
                        for (int k = i + 1; k < V; k++)
                            if (p[i*VW +: 2*W] == p[k*VW +: 2*W]) deg = 1'b1;
`endif
                    if (deg) begin
                        if (m_cull != 16'hFFFF) m_cull = m_cull + 16'd1;
                    end else begin
                        e.prim = p; e.id = m_id;
                        sb.push_back(e);
                        m_id = m_id + 8'd1;
                        push = 1;
                    end
                    m_asm = 0;
                end else begin
                    m_slot[m_asm] = vx;
                    m_asm++;
                end
            end
            m_cnt = m_cnt + push - pop;
        end
        @(posedge clk_in);
        #1;
        valid_in = 1'b0; flush_in = 1'b0;
        chk("count_out", 32'(count_out), 32'(m_cnt));
        chk("valid_out", 32'(valid_out), 32'(m_cnt != 0));
        chk("overflow_out", 32'(overflow_out), 32'(m_ovf));
`ifdef PRIMITIVE_FIFO_DEGEN_CULL_EN
        chk("cull_count_out", 32'(cull_count_out), 32'(m_cull));
`endif
    endtask

    task automatic drain();
        logic a;
        for (int c = 0; c < 50 && m_cnt != 0; c++) cycle(1'b0, '0, 1'b1, 1'b0, a);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (rst_in && !flush_in && valid_out && ready_in) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_prim: id_out=%0d with nothing expected", id_out);
            end else begin
                e = sb.pop_front();
                rx++;
                if (primitive_out !== e.prim || id_out !== e.id) begin
                    fails++;
                    $display("FAIL prim_data: got id %0d prim %h expected id %0d prim %h",
                             id_out, primitive_out, e.id, e.prim);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        int   sent;
        for (int j = 0; j < V - 1; j++) m_slot[j] = '0;

        // Reset state
        #12;
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_ovf", 32'(overflow_out), 32'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;

        // Single primitive, ready_in high
        cycle(1'b1, mkv(1, 1, 10), 1'b1, 1'b0, a);
        cycle(1'b1, mkv(5, 1, 11), 1'b1, 1'b0, a);
        chk("t1_valid_before", 32'(valid_out), 32'd0);
        cycle(1'b1, mkv(1, 5, 12), 1'b1, 1'b0, a);
        chk("t1_valid_after", 32'(valid_out), 32'd1);
        chk("t1_id", 32'(id_out), 32'd0);
        chk("t1_v1_x", primitive_out[VW +: W], 32'd5);
        chk("t1_v2_y", primitive_out[2*VW+W +: W], 32'd5);
        drain();
        chk("t1_count_zero", 32'(count_out), 32'd0);

        // Fill to full, partials still accepted, 15th vertex overflows
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, mkv(100 + i, 200 + i, i), 1'b0, 1'b0, a);
            if (i == 11) chk("t2_count_full", 32'(count_out), 32'd4);
        end
        chk("t2_ready_low", 32'(ready_out), 32'd0);
        cycle(1'b1, mkv(114, 214, 14), 1'b0, 1'b0, a);
        chk("t2_overflow", 32'(overflow_out), 32'd1);
        cycle(1'b1, mkv(114, 214, 14), 1'b1, 1'b0, a);
        chk("t2_ready_after_pop", 32'(ready_out), 32'd1);
        cycle(1'b1, mkv(114, 214, 14), 1'b0, 1'b0, a);
        chk("t2_15th_accepted", 32'(a), 32'd1);
        chk("t2_count_refull", 32'(count_out), 32'd4);

        // Flush with full FIFO + partial, concurrent valid_in/ready_in
        cycle(1'b1, mkv(300, 301, 0), 1'b0, 1'b0, a);
        cycle(1'b1, mkv(310, 311, 0), 1'b1, 1'b1, a);
        chk("t3_count", 32'(count_out), 32'd0);
        chk("t3_valid", 32'(valid_out), 32'd0);
        chk("t3_ovf", 32'(overflow_out), 32'd0);
        cycle(1'b1, mkv(400, 1, 0), 1'b0, 1'b0, a);
        cycle(1'b1, mkv(401, 2, 0), 1'b0, 1'b0, a);
        cycle(1'b1, mkv(402, 3, 0), 1'b0, 1'b0, a);
        chk("t3_id_zero", 32'(id_out), 32'd0);
        drain();

        // Stream 600 primitives with random backpressure; ids wrap at 256
        cycle(1'b0, '0, 1'b0, 1'b1, a);
        rx = 0;
        sent = 0;
        for (int c = 0; c < 20000 && sent < 600 * V; c++) begin
            cycle(1'b1, mkv(sent, 5000 + sent, c), 1'($urandom_range(0, 1)), 1'b0, a);
            if (a) sent++;
        end
        chk("t4_all_sent", 32'(sent), 32'(600 * V));
        drain();
        chk("t4_rx_count", 32'(rx), 32'd600);

        // Async reset mid-primitive
        cycle(1'b1, mkv(1, 2, 0), 1'b0, 1'b0, a);
        cycle(1'b1, mkv(3, 4, 0), 1'b0, 1'b0, a);
        cycle(1'b1, mkv(5, 6, 0), 1'b0, 1'b0, a);
        cycle(1'b1, mkv(7, 8, 0), 1'b0, 1'b0, a);
        cycle(1'b1, mkv(9, 10, 0), 1'b0, 1'b0, a);
        #2;
        rst_in = 1'b0;
        #1;
        chk("t5_count", 32'(count_out), 32'd0);
        chk("t5_valid", 32'(valid_out), 32'd0);
        chk("t5_ready", 32'(ready_out), 32'd1);
        model_reset();
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        cycle(1'b1, mkv(20, 21, 0), 1'b0, 1'b0, a);
        cycle(1'b1, mkv(22, 23, 0), 1'b0, 1'b0, a);
        cycle(1'b1, mkv(24, 25, 0), 1'b0, 1'b0, a);
        chk("t5_id_zero", 32'(id_out), 32'd0);
        chk("t5_v0_x", primitive_out[0 +: W], 32'd20);
        drain();

`ifdef PRIMITIVE_FIFO_DEGEN_CULL_EN
        // Degenerate primitive is culled; next good primitive keeps id 0
        cycle(1'b0, '0, 1'b0, 1'b1, a);
        cycle(1'b1, mkv(2, 3, 0), 1'b0, 1'b0, a);
        cycle(1'b1, mkv(7, 9, 0), 1'b0, 1'b0, a);
        cycle(1'b1, mkv(2, 3, 5), 1'b0, 1'b0, a);
        chk("t6_no_valid", 32'(valid_out), 32'd0);
        chk("t6_cull_one", 32'(cull_count_out), 32'd1);
        cycle(1'b1, mkv(2, 3, 0), 1'b0, 1'b0, a);
        cycle(1'b1, mkv(7, 9, 0), 1'b0, 1'b0, a);
        cycle(1'b1, mkv(8, 3, 0), 1'b0, 1'b0, a);
        chk("t6_id_zero", 32'(id_out), 32'd0);
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/primitive_fifo.md
Name: primitive_fifo

Overview:
- Parametrised primitive-assembly FIFO between viewport_transform and rasterizer.
- Accepts one transformed vertex per cycle and groups every VERTS consecutive vertices into one primitive.
- Stores up to DEPTH complete primitives and presents them to the rasterizer with a show-ahead valid/ready interface.
- Adds flush, primitive sequence IDs, occupancy reporting, sticky overflow and optional degenerate culling.

Parameters:
WIDTH, 32, bits per vertex component
COMPONENTS, 4, components per vertex (x, y, z, w order; component 0 = x, 1 = y)
VERTS, 3, vertices per primitive (≥2)
DEPTH, 8, primitive storage entries (power of two, ≥2)
ID_WIDTH, 8, width of primitive sequence ID

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, asynchronous, active-low
flush_in  input  1  synchronous clear of all contents and state
valid_in  input  1  vertex_in valid
vertex_in  input  COMPONENTS*WIDTH  vertex, component k at bits [k*WIDTH +: WIDTH]
ready_out  output  1  vertex will be accepted this cycle
valid_out  output  1  primitive_out/id_out valid
ready_in  input  1  rasterizer consumes primitive
primitive_out  output  VERTS*COMPONENTS*WIDTH  vertex j at bits [j*COMPONENTS*WIDTH +: COMPONENTS*WIDTH]
id_out  output  ID_WIDTH  sequence ID of head primitive
count_out  output  $clog2(DEPTH+1)  stored primitive count
overflow_out  output  1  sticky: vertex presented while ready_out low

Behaviour:
- Reset (rst_in low, async): count_out=0, valid_out=0, overflow_out=0, id counter=0, assembly index=0, pointers=0. primitive_out/id_out don't-care while valid_out=0.
- Vertex acceptance = valid_in && ready_out.
- ready_out = !(count==DEPTH && asm_idx==VERTS-1). Combinational from registered state only; no path from ready_in.
- Partial vertices are accepted even when full; only the completing vertex stalls.
- Assembly: accepted vertex written to assembly slot asm_idx; asm_idx increments and wraps VERTS-1 → 0.
- On the completing vertex, the primitive (slots 0..VERTS-2 plus vertex_in) and the current id counter are written to mem[wr_ptr]; wr_ptr increments and id counter increments, wrapping mod 2^ID_WIDTH.
- Latency: completing vertex accepted at cycle N → valid_out=1 at N+1 when empty before.
- Output is show-ahead:
  - valid_out = (count!=0).
  - primitive_out/id_out = mem[rd_ptr], registered.
  - Pop = valid_out && ready_in; rd_ptr increments.
- Simultaneous push and pop: count unchanged; data ordering preserved. When count==DEPTH-1, push+pop leaves count=DEPTH-1.
- Pointers wrap at DEPTH naturally (log2 width).
- Overflow: valid_in && !ready_out sets overflow_out. The vertex is discarded and asm_idx is unchanged. overflow_out clears only on reset or flush.
- flush_in (synchronous) clears count, pointers, asm_idx, id counter and overflow. It overrides a simultaneous push/pop: the vertex is not accepted and nothing is popped. valid_out=0 the next cycle.
- Async reset mid-primitive discards partial assembly; the first vertex after reset is slot 0.

Optional Feature:
PRIMITIVE_FIFO_DEGEN_CULL_EN
- Defined:
  - On the completing vertex, if any two vertices of the primitive have identical x and y (components 0 and 1, bitwise compare), the primitive is discarded: not stored, id counter not incremented, ready_out unaffected.
  - Adds output port cull_count_out (16 bits), reset/flush to 0, incrementing per culled primitive and saturating at 16'hFFFF.
- Undefined: no comparison is made, all primitives are stored, and the cull_count_out port is absent.

Test Plan:
- Reset, then 3 vertices (x,y = 1,1 / 5,1 / 1,5) with ready_in=1 → valid_out high exactly one cycle after the 3rd vertex, id_out=0, primitive_out slot order matches input order, count_out returns to 0 after pop.
- DEPTH=4, ready_in=0, push 14 vertices → count_out=4 after the 12th; vertices 13–14 accepted with ready_out=1. Present a 15th: ready_out=0, overflow_out=1, asm_idx stays 2. Then one pop → ready_out=1 and the 15th vertex is accepted, count_out=4.
- Continuous streaming of 600 primitives with random ready_in → id_out sequence 0..255,0..255,0..87 (wraps), no loss, no duplication, order preserved.
- Full FIFO with 1 partial vertex; assert flush_in simultaneously with valid_in and ready_in → next cycle count_out=0, valid_out=0, overflow_out=0; the next 3 vertices form a primitive with id_out=0.
- Drop rst_in asynchronously mid-clock after 2 vertices → outputs reach reset values before the next edge; a following 3-vertex group forms a primitive with id_out=0.
- With PRIMITIVE_FIFO_DEGEN_CULL_EN: vertices (2,3),(7,9),(2,3) → no valid_out, cull_count_out=1. The next non-degenerate primitive has id_out=0.
